mm2s_read_scheduler: RTL and testbench

- Sequences AXI read-address bursts for the MM2S path so that returned data beats always fit in the downstream beat FIFO.
- Accepts one transfer command (start address, beat count) and splits it into bursts. Each burst is limited by BURST_MAX, by the 4 KB boundary, and by the FIFO space not already claimed.
- Sits between the command source and the AXI AR channel. It watches FIFO writes and the FIFO occupancy count.

---
 rtl/mm2s_pkg.sv | 12 +
 rtl/credit_counter.sv | 31 +++
 rtl/mm2s_read_scheduler.sv | 90 +++++++++
 tb/tb_mm2s_read_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm2s_pkg.sv
// mm2s_pkg: scheduler states, AXI 4 KB constant and burst sizing shared by the MM2S read path.
package mm2s_pkg;
  typedef enum logic [2:0] {IDLE, CALC, WAIT, ISSUE, DRAIN, DONE} sched_state_t;
  localparam int AXI_4K = 4096;
  function automatic logic [31:0] calc_blen(input logic [31:0] remaining, input logic [11:0] addr_lo,
                                            input int burst_max, input int beat_bytes);
    logic [31:0] to_4k, lim;
    to_4k = (32'(AXI_4K) - 32'(addr_lo)) / 32'(beat_bytes);
    lim = (remaining < 32'(burst_max)) ? remaining : 32'(burst_max);
    return (lim < to_4k) ? lim : to_4k;
  endfunction
endpackage

// File: rtl/credit_counter.sv
// credit_counter: outstanding-beat credit count with a sticky underflow/overflow error flag.
module credit_counter #(
  parameter int W     = 5,
  parameter int LIMIT = 16,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          add_en,
  input  logic [AW-1:0] add,
  input  logic          dec,
  output logic [W-1:0]  count,
  output logic          err
);
  logic [31:0] sum;
  logic under, over;
  always_comb begin
    under = dec && count == '0;
    sum = 32'(count) + (add_en ? 32'(add) : 32'd0) - ((dec && !under) ? 32'd1 : 32'd0);
    over = sum > 32'(LIMIT);
  end
  // an underflowing decrement is dropped so the count holds at zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      err <= 1'b0;
    end else begin
      count <= over ? W'(LIMIT) : W'(sum);
      err <= err | under | over;
    end
endmodule

// File: rtl/mm2s_read_scheduler.sv
// mm2s_read_scheduler: splits a read command into AXI AR bursts bounded by BURST_MAX, 4 KB
// and unclaimed FIFO space, so returned beats always fit in the downstream beat FIFO.
module mm2s_read_scheduler
  import mm2s_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 16,
  parameter int BEAT_BYTES   = 4,
  parameter int BURST_MAX    = 16,
  parameter int FIFO_ADDR_SZ = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_beats,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_W-1:0]     ar_addr,
  output logic [7:0]            ar_len,
  input  logic                  beat_wr,
  input  logic [FIFO_ADDR_SZ:0] fifo_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int FIFO_DEPTH = 1 << FIFO_ADDR_SZ;
  localparam int CW = FIFO_ADDR_SZ + 1;
  sched_state_t state, nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0] remaining;
  logic [8:0] blen;
  logic [CW-1:0] inflight, free;
  logic hs;
  assign hs = ar_valid && ar_ready;
  assign free = CW'(FIFO_DEPTH) - fifo_count - inflight;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ar_valid = state == ISSUE;
  credit_counter #(.W(CW), .LIMIT(FIFO_DEPTH), .AW(9)) u_credit (
    .clk    (clk),
    .reset_n(reset_n),
    .add_en (hs),
    .add    ({1'b0, ar_len} + 9'd1),
    .dec    (beat_wr),
    .count  (inflight),
    .err    (err)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) nxt = (cmd_beats == '0) ? DONE : CALC;
      CALC:    nxt = WAIT;
      WAIT:    if (32'(free) >= 32'(blen)) nxt = ISSUE;
      ISSUE:   if (ar_ready) nxt = (remaining != LEN_W'(blen)) ? CALC : DRAIN;
      DRAIN:   if (inflight == '0 || (inflight == CW'(1) && beat_wr)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      blen <= '0;
      ar_addr <= '0;
      ar_len <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && cmd_valid) begin
        cur_addr <= cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
        remaining <= cmd_beats;
      end
      if (state == CALC) blen <= 9'(calc_blen(32'(remaining), cur_addr[11:0], BURST_MAX, BEAT_BYTES));
      if (state == WAIT && nxt == ISSUE) begin
        ar_addr <= cur_addr;
        ar_len <= 8'(blen - 9'd1);
      end
      if (hs) begin
        cur_addr <= cur_addr + ADDR_W'(32'(blen) * BEAT_BYTES);
        remaining <= remaining - LEN_W'(blen);
      end
    end
  // claimed space plus stored beats must never exceed the FIFO
  assert property (@(posedge clk) disable iff (!reset_n)
    32'(inflight) + 32'(fifo_count) <= 32'(FIFO_DEPTH));
endmodule

// File: tb/tb_mm2s_read_scheduler.sv
// tb_mm2s_read_scheduler: scoreboard bench with an AXI read slave and beat FIFO model.
module tb_mm2s_read_scheduler;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [7:0] ar_len;
  logic beat_wr;
  logic [4:0] fifo_count;
  logic busy, done, err;

  mm2s_read_scheduler #(.ADDR_W(32), .LEN_W(16), .BEAT_BYTES(4), .BURST_MAX(8), .FIFO_ADDR_SZ(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_beats(cmd_beats), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .beat_wr(beat_wr), .fifo_count(fifo_count), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  ar_t exp_q[$];
  int due_q[$];
  int vectors = 0, miscompares = 0;
  int cyc_m = 0, fifo_cnt = 0, inflight_m = 0, pend_add = 0, pend_dec = 0, last_due = 0;
  int last_fifo = 0, occ_max = 0, beats_seen = 0, beats_at_done = 0, hs_count = 0, stall_cnt = 0, stalls = 0;
  logic bw_prev = 1'b0, pop_en = 1'b1, spur = 1'b0;

  // AXI slave returns beats from 2 cycles after each AR; FIFO pops one beat per cycle when enabled
  initial begin
    beat_wr = 1'b0;
    fifo_count = '0;
    ar_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc_m++;
      if (!reset_n) begin
        beat_wr = 1'b0; fifo_count = '0; fifo_cnt = 0; bw_prev = 1'b0; inflight_m = 0;
        pend_add = 0; pend_dec = 0; due_q.delete(); last_due = 0;
        continue;
      end
      inflight_m += pend_add - pend_dec;
      pend_add = 0; pend_dec = 0;
      last_fifo = fifo_cnt;
      fifo_cnt += int'(bw_prev);
      if (pop_en && fifo_cnt > 0) fifo_cnt--;
      fifo_count = 5'(fifo_cnt);
      if (inflight_m + fifo_cnt > occ_max) occ_max = inflight_m + fifo_cnt;
      bw_prev = 1'b0;
      if (spur) begin
        spur = 1'b0; bw_prev = 1'b1; pend_dec = (inflight_m > 0) ? 1 : 0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc_m) begin
        void'(due_q.pop_front()); bw_prev = 1'b1; pend_dec = 1; beats_seen++;
      end
      beat_wr = bw_prev;
      ar_ready = (stall_cnt == 0);
      #1;
      if (ar_valid && !ar_ready) begin
        stall_cnt--; stalls++;
        if (exp_q.size() > 0) begin
          vectors++;
          if (ar_addr !== exp_q[0].addr || ar_len !== exp_q[0].len) begin
            miscompares++;
            $display("FAIL ar_stable: got addr=%h len=%0d, expected addr=%h len=%0d", ar_addr, ar_len, exp_q[0].addr, exp_q[0].len);
          end
        end
      end else if (ar_valid) begin
        ar_t e;
        hs_count++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ar_unexpected: got addr=%h len=%0d, expected no burst", ar_addr, ar_len);
        end else begin
          e = exp_q.pop_front();
          if (ar_addr !== e.addr || ar_len !== e.len) begin
            miscompares++;
            $display("FAIL ar_burst: got addr=%h len=%0d, expected addr=%h len=%0d", ar_addr, ar_len, e.addr, e.len);
          end
        end
        for (int k = 0; k <= int'(ar_len); k++) begin
          last_due = (cyc_m + 2 > last_due + 1) ? cyc_m + 2 : last_due + 1;
          due_q.push_back(last_due);
        end
        pend_add = int'(ar_len) + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n;
    #2;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL cmd_ready_idle: got %b, expected 1", cmd_ready); end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat_ar, output int lat_done, output int busy_n);
    lat_ar = -1; lat_done = -1; busy_n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk); #2;
      if (busy) busy_n++;
      if (ar_valid && lat_ar < 0) lat_ar = i;
      if (done) begin lat_done = i; beats_at_done = beats_seen; break; end
    end
    vectors++;
    if (lat_done < 0) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end else begin
      @(negedge clk); #2;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL done_pulse: got done=%b cmd_ready=%b, expected done=0 cmd_ready=1", done, cmd_ready);
      end
    end
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [15:0] n, output int lat_ar, output int lat_done, output int busy_n);
    beats_seen = 0;
    start_cmd(a, n);
    wait_done(300, lat_ar, lat_done, busy_n);
    vectors++;
    if (exp_q.size() != 0 || beats_at_done != int'(n) || err !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_complete: got pending=%0d beats=%0d err=%b, expected pending=0 beats=%0d err=0", exp_q.size(), beats_at_done, err, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #2;
    vectors++;
    if ({cmd_ready, ar_valid, busy, done, err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/av/busy/done/err=%b, expected 10000", {cmd_ready, ar_valid, busy, done, err});
    end
    vectors++;
    if (ar_addr !== 32'h0 || ar_len !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_ar: got addr=%h len=%0d, expected 0/0", ar_addr, ar_len);
    end
  endtask

  task automatic test_basic();
    int la, ld, bn;
    push_exp(32'h1000, 8'd7); push_exp(32'h1020, 8'd7); push_exp(32'h1040, 8'd3);
    run_cmd(32'h1000, 16'd20, la, ld, bn);
    vectors++;
    if (la != 3) begin miscompares++; $display("FAIL first_ar_latency: got %0d, expected 3", la); end
  endtask

  task automatic test_4k();
    int la, ld, bn;
    push_exp(32'h0FF8, 8'd1); push_exp(32'h1000, 8'd5);
    run_cmd(32'h0FF8, 16'd8, la, ld, bn);
  endtask

  task automatic test_zero();
    int la, ld, bn, h0;
    h0 = hs_count;
    run_cmd(32'h40, 16'd0, la, ld, bn);
    vectors++;
    if (ld != 1 || bn != 1 || la != -1 || hs_count != h0) begin
      miscompares++;
      $display("FAIL zero_beats: got done_lat=%0d busy=%0d ar_lat=%0d hs=%0d, expected 1/1/-1/0", ld, bn, la, hs_count - h0);
    end
  endtask

  task automatic test_stall();
    int la, ld, bn, h0;
    h0 = hs_count; stalls = 0; stall_cnt = 5;
    push_exp(32'h2000, 8'd3);
    run_cmd(32'h2000, 16'd4, la, ld, bn);
    vectors++;
    if (stalls != 5 || hs_count - h0 != 1) begin
      miscompares++;
      $display("FAIL stall_hs: got stalls=%0d hs=%0d, expected 5/1", stalls, hs_count - h0);
    end
  endtask

  task automatic test_backpressure();
    int la, ld, bn, h0, i;
    h0 = hs_count; occ_max = 0; beats_seen = 0; pop_en = 1'b0;
    push_exp(32'h0, 8'd7); push_exp(32'h20, 8'd7); push_exp(32'h40, 8'd7); push_exp(32'h60, 8'd7);
    start_cmd(32'h0, 16'd32);
    for (i = 0; i < 100 && fifo_cnt != 16; i++) begin @(negedge clk); #2; end
    vectors++;
    if (fifo_cnt != 16) begin miscompares++; $display("FAIL fifo_fill: got %0d, expected 16", fifo_cnt); end
    repeat (5) @(negedge clk);
    #2;
    vectors++;
    if (hs_count - h0 != 2 || ar_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL third_ar_held: got hs=%0d ar_valid=%b, expected 2/0", hs_count - h0, ar_valid);
    end
    pop_en = 1'b1;
    for (i = 0; i < 40 && ar_valid !== 1'b1; i++) begin @(negedge clk); #2; end
    vectors++;
    if (ar_valid !== 1'b1 || last_fifo != 8) begin
      miscompares++;
      $display("FAIL third_ar_release: got ar_valid=%b fifo_count_before=%0d, expected 1/8", ar_valid, last_fifo);
    end
    wait_done(300, la, ld, bn);
    vectors++;
    if (occ_max != 16 || exp_q.size() != 0 || beats_at_done != 32) begin
      miscompares++;
      $display("FAIL credit_bound: got max_occ=%0d pending=%0d beats=%0d, expected 16/0/32", occ_max, exp_q.size(), beats_at_done);
    end
  endtask

  task automatic test_reset_mid();
    int la, ld, bn, i;
    stall_cnt = 1000;
    push_exp(32'h3000, 8'd3);
    start_cmd(32'h3000, 16'd4);
    for (i = 0; i < 10 && ar_valid !== 1'b1; i++) begin @(negedge clk); #2; end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ar_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || i >= 10) begin
      miscompares++;
      $display("FAIL async_reset: got ar_valid=%b cmd_ready=%b busy=%b wait=%0d, expected 0/1/0/<10", ar_valid, cmd_ready, busy, i);
    end
    exp_q.delete();
    stall_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (dut.inflight !== 5'd0) begin miscompares++; $display("FAIL inflight_after_reset: got %0d, expected 0", dut.inflight); end
    push_exp(32'h3000, 8'd3);
    run_cmd(32'h3000, 16'd4, la, ld, bn);
    vectors++;
    if (la != 3) begin miscompares++; $display("FAIL post_reset_latency: got %0d, expected 3", la); end
    spur = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b, expected 1", err); end
    repeat (5) @(negedge clk);
    #2;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b, expected 1", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_4k();
    test_zero();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
